// File: rtl/clk_step_ctrl_if.sv
// clk_step_ctrl_if: board switch/key/halt inputs and CPU/display outputs of the step controller
//   master: drives SW_choose, SW_run, KEY_step, halt; observes the outputs
//   slave : the controller; drives cpu_tick, clk_light, tick_cnt, quick_low_led, run_led
interface clk_step_ctrl_if;
  logic       SW_choose;
  logic       SW_run;
  logic       KEY_step;
  logic       halt;
  logic       cpu_tick;
  logic       clk_light;
  logic [7:0] tick_cnt;
  logic       quick_low_led;
  logic       run_led;
  modport master (
    output SW_choose, SW_run, KEY_step, halt,
    input  cpu_tick, clk_light, tick_cnt, quick_low_led, run_led
  );
  modport slave (
    input  SW_choose, SW_run, KEY_step, halt,
    output cpu_tick, clk_light, tick_cnt, quick_low_led, run_led
  );
endinterface

// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: CPU execute-enable generator (fast/slow run or debounced single step) plus display refresh clock
//   clk   : board clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of clk_step_ctrl_if (async switches/key, halt in; cpu_tick, clk_light, tick_cnt, LEDs out)
module clk_step_ctrl #(
  parameter int FAST_DIV   = 2_500_000,
  parameter int SLOW_DIV   = 25_000_000,
  parameter int LIGHT_DIV  = 50_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_step_ctrl_if.slave bus
);
  localparam int RMAX = FAST_DIV > SLOW_DIV ? FAST_DIV : SLOW_DIV;
  localparam int RW   = $clog2(RMAX);
  localparam int DW   = $clog2(DEB_CYCLES);
  localparam int LW   = $clog2(LIGHT_DIV + 1);
  localparam logic [RW-1:0] FAST_M1  = RW'(FAST_DIV - 1);
  localparam logic [RW-1:0] SLOW_M1  = RW'(SLOW_DIV - 1);
  localparam logic [DW-1:0] DEB_M1   = DW'(DEB_CYCLES - 1);
  localparam logic [LW-1:0] LIGHT_M1 = LW'(LIGHT_DIV - 1);
  logic          r_sc_m, r_sc_s, r_sc_p;
  logic          r_sr_m, r_sr_s, r_sr_p;
  logic          r_ky_m, r_ky_s;
  logic          r_deb_key, r_deb_prev, r_press;
  logic          r_tick, r_light;
  logic [DW-1:0] r_deb_cnt;
  logic [RW-1:0] r_rate_cnt;
  logic [LW-1:0] r_lt_cnt;
  logic [7:0]    r_tick_cnt;
  logic          w_sc_chg, w_sr_chg, w_chg, w_wrap, w_deb_hit, w_lt_wrap;
  logic [RW-1:0] w_div_m1;
  always_comb begin
    w_sc_chg  = r_sc_s != r_sc_p;
    w_sr_chg  = r_sr_s != r_sr_p;
    w_chg     = w_sc_chg | w_sr_chg;
    w_div_m1  = r_sc_s ? FAST_M1 : SLOW_M1;
    // >= rather than == so a switch to the shorter divider never overruns
    w_wrap    = r_rate_cnt >= w_div_m1;
    w_deb_hit = r_deb_cnt == DEB_M1;
    w_lt_wrap = r_lt_cnt == LIGHT_M1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sc_m     <= 1'b0;
      r_sc_s     <= 1'b0;
      r_sc_p     <= 1'b0;
      r_sr_m     <= 1'b0;
      r_sr_s     <= 1'b0;
      r_sr_p     <= 1'b0;
      r_ky_m     <= 1'b1;
      r_ky_s     <= 1'b1;
      r_deb_key  <= 1'b1;
      r_deb_prev <= 1'b1;
      r_press    <= 1'b0;
      r_deb_cnt  <= '0;
      r_rate_cnt <= '0;
      r_tick     <= 1'b0;
      r_tick_cnt <= '0;
      r_lt_cnt   <= '0;
      r_light    <= 1'b0;
    end else begin
      r_sc_m     <= bus.SW_choose;
      r_sc_s     <= r_sc_m;
      r_sc_p     <= r_sc_s;
      r_sr_m     <= bus.SW_run;
      r_sr_s     <= r_sr_m;
      r_sr_p     <= r_sr_s;
      r_ky_m     <= bus.KEY_step;
      r_ky_s     <= r_ky_m;
      r_deb_cnt  <= (r_ky_s == r_deb_key || w_deb_hit) ? '0 : r_deb_cnt + DW'(1);
      if (r_ky_s != r_deb_key && w_deb_hit) r_deb_key <= r_ky_s;
      r_deb_prev <= r_deb_key;
      // only the press (1->0) edge of the debounced key counts
      r_press    <= r_deb_prev & ~r_deb_key;
      r_rate_cnt <= (w_chg | w_wrap) ? '0 : r_rate_cnt + RW'(1);
      // a switch change in a wrap cycle clears the counter and swallows that tick
      r_tick     <= ~bus.halt & (r_sr_s ? (w_wrap & ~w_chg) : (r_press & ~w_sr_chg));
      r_tick_cnt <= r_tick_cnt + {7'd0, r_tick};
      r_lt_cnt   <= w_lt_wrap ? '0 : r_lt_cnt + LW'(1);
      if (w_lt_wrap) r_light <= ~r_light;
    end
  end
  assign bus.cpu_tick      = r_tick;
  assign bus.clk_light     = r_light;
  assign bus.tick_cnt      = r_tick_cnt;
  assign bus.quick_low_led = r_sc_s;
  assign bus.run_led       = r_sr_s;
endmodule

// File: doc/clk_step_ctrl.md
# clk_step_ctrl

Clock-rate and single-step controller for the 8-bit CPU board. It sits directly upstream of the light display unit and the CPU core. It derives a free-running display refresh clock (`clk_light`) and a one-cycle CPU execute enable (`cpu_tick`) from the 50 MHz board clock. `cpu_tick` runs at a fast or slow rate, or one pulse per debounced press of the step key.

## Interface
Parameters:
- `FAST_DIV`, 2_500_000, cycles per `cpu_tick` in fast run mode (≥2)
- `SLOW_DIV`, 25_000_000, cycles per `cpu_tick` in slow run mode (≥2)
- `LIGHT_DIV`, 50_000, cycles per half-period of `clk_light` (≥1)
- `DEB_CYCLES`, 1_000_000, consecutive stable cycles required to accept a key level (≥2)

Ports:
- `clk`  in  1  board clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `SW_choose`  in  1  speed select, asynchronous; 1 = fast, 0 = slow
- `SW_run`  in  1  mode select, asynchronous; 1 = free run, 0 = single step
- `KEY_step`  in  1  step pushbutton, asynchronous, active-low (0 = pressed)
- `halt`  in  1  CPU halted, from controller, synchronous to `clk`
- `cpu_tick`  out  1  one-cycle CPU execute enable
- `clk_light`  out  1  square-wave refresh clock for the light display
- `tick_cnt`  out  8  number of `cpu_tick` pulses issued, modulo 256
- `quick_low_led`  out  1  synchronized `SW_choose`
- `run_led`  out  1  synchronized `SW_run`

## Operation
- Synchronizers: `SW_choose`, `SW_run`, and `KEY_step` each pass through a two-flop synchronizer. The sync values are `sc_s`, `sr_s`, and `ky_s`.
- Debounce: `deb_cnt` increments each cycle while `ky_s != deb_key` and clears when they are equal. When `deb_cnt == DEB_CYCLES-1` and the inputs still differ, `deb_key <= ky_s` and `deb_cnt <= 0`.
- Press event: `press = deb_key_prev & ~deb_key`, registered 1→0 edge of `deb_key`. A release produces no event.
- Rate counter `rate_cnt`:
  - Wraps at `DIV-1`, where `DIV = sc_s ? FAST_DIV : SLOW_DIV`. Wrapping applies if `rate_cnt >= DIV-1`, which guards against overrun.
  - Cleared to 0 on any cycle where `sc_s` or `sr_s` differs from its value on the previous cycle.
- Tick generation, registered, one cycle wide:
  - Run mode (`sr_s=1`): `cpu_tick` is asserted in the cycle after a `rate_cnt` wrap, unless `halt` was high in the wrap cycle.
  - Step mode (`sr_s=0`): `cpu_tick` is asserted in the cycle after `press`, unless `halt` is high in the `press` cycle.
  - Presses in run mode are discarded and are not queued.
  - A mode change clears `rate_cnt` and produces no tick.
- `tick_cnt` increments on every cycle where `cpu_tick=1` and wraps from 255 to 0.
- `clk_light` counter `lt_cnt` runs 0..LIGHT_DIV-1. `clk_light` toggles on each wrap. It is independent of mode, speed, and `halt`.
- `halt` only suppresses ticks; no state is cleared. Ticks resume at the next qualifying wrap or press after `halt` falls.
- `quick_low_led = sc_s`; `run_led = sr_s`.

## Timing
- Reset values:
  - `cpu_tick=0`, `clk_light=0`, `tick_cnt=0`
  - `quick_low_led=0`, `run_led=0`
  - `rate_cnt=0`, `lt_cnt=0`, `deb_cnt=0`
  - Synchronizer flops: 0 for the switches, 1 for the key
  - `deb_key=1`, `deb_key_prev=1`
- Reset asserted mid-count or mid-debounce abandons all progress. A key held through reset must be re-debounced after release of `rst_n`.
- Switch latency: 2 cycles from the input change to the LED change.
- Press latency: `KEY_step` falls at edge E.
  - `ky_s` changes at E+2.
  - `deb_key` falls at E+2+DEB_CYCLES.
  - `press` is high at E+3+DEB_CYCLES.
  - `cpu_tick` is high at E+4+DEB_CYCLES.
- Bounce: any glitch shorter than `DEB_CYCLES` cycles after synchronization produces no `deb_key` change.
- Run-mode period: exactly `DIV` cycles between consecutive `cpu_tick` pulses when switches are stable.
  - The first tick after a switch change occurs `DIV`+1 cycles after the clearing cycle.
- `clk_light` period: `2*LIGHT_DIV` cycles, 50% duty.
- A switch change in the same cycle as a wrap: the clear wins, and no tick is issued for that wrap.

## Test plan
Parameters for all scenarios: `FAST_DIV=4`, `SLOW_DIV=10`, `LIGHT_DIV=3`, `DEB_CYCLES=5`.

- Reset/free-run: `rst_n=0` for 3 cycles with `SW_run=1` and `SW_choose=1`, then release and wait 20 cycles → all outputs are 0 during reset. `cpu_tick` then repeats every 4 cycles, `tick_cnt` counts 1,2,3…, and `clk_light` toggles every 3 cycles.
- Speed switch: in run/fast mode, set `SW_choose=0` → `quick_low_led=0` after 2 cycles. The next tick occurs 11 cycles after the clear, then ticks repeat every 10 cycles, with no extra or missing pulse beyond this.
- Single step with bounce: set `SW_run=0`, then drive `KEY_step` 1,0,1,0 in 1-cycle glitches, then hold it at 0 for 10 cycles → exactly one `cpu_tick`, 9 cycles after the start of the stable low. Releasing the key produces no tick.
- Halt: in run/fast mode, assert `halt` for 10 cycles → no `cpu_tick` while it is high. Ticks resume on the first wrap after `halt` falls, and `tick_cnt` is unchanged during the halt.
- Presses in run mode: in run mode, give a clean 10-cycle press → the tick cadence is unchanged and no extra pulse appears. Switching to step mode afterwards produces no tick until a new press.
- Wrap and reset mid-debounce: issue 256 steps → `tick_cnt` returns to 0. Assert `rst_n=0` with `KEY_step` held low, then release → no tick until `DEB_CYCLES`+4 cycles after release, and no tick at all if the key is released before then.
